// File: rtl/pkt_fifo_pkg.sv
// Shared constants and FSM encoding for the packet FIFO with commit/rollback.
// Default widths match the production configuration.
package pkt_fifo_pkg;

    localparam int DEF_DATA_W       = 16;
    localparam int DEF_ADDR_W       = 10;
    localparam int DEF_AFULL_THRESH = 2**DEF_ADDR_W - 128;

    localparam logic [0:0] ST_IDLE_ENC = 1'b0;
    localparam logic [0:0] ST_OPEN_ENC = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_OPEN = ST_OPEN_ENC
    } pkt_state_e;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered output.
// The output register resets to zero and holds its value when no read is issued.
module sdp_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Kept as a plain enabled output register so tools map it onto the block RAM output latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pkt_fifo_rollback.sv
// Packet FIFO: writes outside a packet stream straight through; writes inside a
// packet stay hidden from the reader until committed, and can be rolled back.
module pkt_fifo_rollback
    import pkt_fifo_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int AFULL_THRESH = 2**ADDR_W - 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pkt_start,
    input  logic              pkt_commit,
    input  logic              pkt_rollback,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic              almost_full,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   used,
    output logic              pkt_open,
    output logic              overflow,
    input  logic              ovf_clr
);

    localparam logic [ADDR_W:0] DEPTH_P = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] AFULL_P = (ADDR_W+1)'(AFULL_THRESH);

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] commit_ptr_q, commit_ptr_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] start_ptr_q, start_ptr_d;
    pkt_state_e      state_q, state_d;
    logic            overflow_q, overflow_d;
    logic            rd_valid_q, rd_valid_d;

    logic [ADDR_W:0] used_w;
    logic [ADDR_W:0] count_w;
    logic            full_w;
    logic            empty_w;
    logic            wr_ok;
    logic            rd_fire;
    logic            ram_we;
    logic [ADDR_W:0] wr_base;

    assign used_w  = wr_ptr_q - rd_ptr_q;
    assign count_w = commit_ptr_q - rd_ptr_q;
    assign full_w  = (used_w == DEPTH_P);
    assign empty_w = (count_w == '0);

    // Write side: wr_base is where this cycle's write lands, which is start_ptr
    // when a new pkt_start implicitly discards an open packet.
    always_comb begin
        wr_ok        = wr_en && !full_w;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        start_ptr_d  = start_ptr_q;
        state_d      = state_q;
        wr_base      = wr_ptr_q;
        ram_we       = 1'b0;

        if (state_q == ST_OPEN && pkt_rollback) begin
            wr_ptr_d = start_ptr_q;
            state_d  = ST_IDLE;
        end else begin
            if (pkt_start) begin
                if (state_q == ST_OPEN) begin
                    wr_base = start_ptr_q;
                end
                start_ptr_d = wr_base;
                state_d     = ST_OPEN;
            end
            ram_we   = wr_ok;
            wr_ptr_d = wr_base + {{ADDR_W{1'b0}}, wr_ok};
            if (!pkt_start) begin
                if (state_q == ST_IDLE) begin
                    commit_ptr_d = wr_ptr_d;
                end else if (pkt_commit) begin
                    commit_ptr_d = wr_ptr_d;
                    state_d      = ST_IDLE;
                end
            end
        end
    end

    always_comb begin
        rd_fire    = rd_en && !empty_w;
        rd_ptr_d   = rd_ptr_q + {{ADDR_W{1'b0}}, rd_fire};
        rd_valid_d = rd_fire;
        // A dropped write wins over a same-cycle clear so no drop goes unreported.
        if (wr_en && full_w) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            start_ptr_q  <= '0;
            state_q      <= ST_IDLE;
            overflow_q   <= 1'b0;
            rd_valid_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            start_ptr_q  <= start_ptr_d;
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    sdp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .waddr (wr_base[ADDR_W-1:0]),
        .wdata (wr_data),
        .re    (rd_fire),
        .raddr (rd_ptr_q[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    assign rd_valid    = rd_valid_q;
    assign empty       = empty_w;
    assign full        = full_w;
    assign almost_full = (used_w >= AFULL_P);
    assign count       = count_w;
    assign used        = used_w;
    assign pkt_open    = (state_q == ST_OPEN);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_pkt_fifo_rollback.sv
// Directed bench for pkt_fifo_rollback with a committed-word scoreboard and
// a pending-packet queue modelling the uncommitted region.
module tb_pkt_fifo_rollback;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int DEPTH = 16;
    localparam int AFULL = 12;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          pkt_start;
    logic          pkt_commit;
    logic          pkt_rollback;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [AW:0]   count;
    logic [AW:0]   used;
    logic          pkt_open;
    logic          overflow;
    logic          ovf_clr;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] pend[$];
    bit            m_open;
    bit            m_ovf;
    logic [DW-1:0] last_rd;

    pkt_fifo_rollback #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .AFULL_THRESH (AFULL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .pkt_start    (pkt_start),
        .pkt_commit   (pkt_commit),
        .pkt_rollback (pkt_rollback),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .count        (count),
        .used         (used),
        .pkt_open     (pkt_open),
        .overflow     (overflow),
        .ovf_clr      (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        int u;
        u = sb.size() + pend.size();
        chk({tag, " count"},       32'(count),       32'(sb.size()));
        chk({tag, " used"},        32'(used),        32'(u));
        chk({tag, " empty"},       32'(empty),       32'(sb.size() == 0));
        chk({tag, " full"},        32'(full),        32'(u == DEPTH));
        chk({tag, " almost_full"}, 32'(almost_full), 32'(u >= AFULL));
        chk({tag, " pkt_open"},    32'(pkt_open),    32'(m_open));
        chk({tag, " overflow"},    32'(overflow),    32'(m_ovf));
    endtask

    // One clock of stimulus; the model is updated from the pre-edge state.
    task automatic op(input bit s, input bit c, input bit r, input bit w,
                      input bit rdn, input bit clr, input logic [DW-1:0] d);
        bit            full_pre;
        bit            exp_v;
        logic [DW-1:0] exp_rd;
        full_pre = (sb.size() + pend.size()) == DEPTH;
        exp_v    = 1'b0;
        exp_rd   = last_rd;
        if (rdn && sb.size() > 0) begin
            exp_v  = 1'b1;
            exp_rd = sb.pop_front();
        end
        pkt_start = s; pkt_commit = c; pkt_rollback = r;
        wr_en = w; wr_data = d; rd_en = rdn; ovf_clr = clr;
        tick();
        pkt_start = 0; pkt_commit = 0; pkt_rollback = 0;
        wr_en = 0; rd_en = 0; ovf_clr = 0;

        if (m_open && r) begin
            pend.delete();
            m_open = 0;
        end else if (s) begin
            pend.delete();
            if (w && !full_pre) pend.push_back(d);
            m_open = 1;
        end else if (m_open && c) begin
            if (w && !full_pre) pend.push_back(d);
            for (int i = 0; i < pend.size(); i++) sb.push_back(pend[i]);
            pend.delete();
            m_open = 0;
        end else if (w && !full_pre) begin
            if (m_open) pend.push_back(d);
            else        sb.push_back(d);
        end
        if (w && full_pre) m_ovf = 1;
        else if (clr)      m_ovf = 0;

        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("rd_data",  32'(rd_data),  32'(exp_rd));
        last_rd = exp_rd;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        op(0, 0, 0, 1, 0, 0, d);
    endtask

    task automatic rd();
        op(0, 0, 0, 0, 1, 0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1 && sb.size() > 0; i++) rd();
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        pkt_start = 0; pkt_commit = 0; pkt_rollback = 0;
        wr_en = 0; wr_data = '0; rd_en = 0; ovf_clr = 0;
        tick();
        rst = 0;
        sb.delete(); pend.delete();
        m_open = 0; m_ovf = 0; last_rd = '0;
        chk_flags(tag);
        chk({tag, " rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, " rd_data"},  32'(rd_data),  32'd0);
    endtask

    initial begin
        do_reset("reset");

        // Streaming writes visible immediately
        for (int i = 0; i < 5; i++) begin
            wr(16'hA001 + 16'(i));
            chk_flags("stream_wr");
        end
        for (int i = 0; i < 5; i++) begin
            rd();
            chk_flags("stream_rd");
        end
        rd();
        chk_flags("empty_rd");

        // Packet hidden until commit
        op(1, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 4; i++) wr(16'hB001 + 16'(i));
        chk_flags("pkt_hidden");
        rd();
        op(0, 1, 0, 0, 0, 0, '0);
        chk_flags("pkt_commit");
        drain();
        chk_flags("pkt_drain");

        // Start with same-cycle write, commit with same-cycle write
        op(1, 0, 0, 1, 0, 0, 16'hC001);
        wr(16'hC002);
        op(0, 1, 0, 1, 0, 0, 16'hC003);
        chk_flags("commit_wr");
        drain();

        // Rollback discards open packet and same-cycle write
        op(1, 0, 0, 0, 0, 0, '0);
        wr(16'hD001);
        wr(16'hD002);
        op(0, 1, 0, 0, 0, 0, '0);
        op(1, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) wr(16'hE001 + 16'(i));
        op(0, 0, 1, 1, 0, 0, 16'hE004);
        chk_flags("rollback");
        drain();
        rd();
        chk_flags("rollback_drain");

        // Fill, overflow, set-over-clear priority, read does not free space
        for (int i = 0; i < DEPTH; i++) begin
            wr(16'hF000 + 16'(i));
            chk_flags("fill");
        end
        wr(16'hFFFF);
        chk_flags("ovf_set");
        op(0, 0, 0, 1, 0, 1, 16'hFFFE);
        chk_flags("ovf_set_over_clr");
        op(0, 0, 0, 1, 1, 0, 16'hFFFD);
        chk_flags("full_rd_wr");
        op(0, 0, 0, 0, 0, 1, '0);
        chk_flags("ovf_clr");
        drain();
        chk_flags("full_drain");

        // Three packets across pointer wrap with concurrent reads
        for (int p = 0; p < 3; p++) begin
            op(1, 0, 0, 0, 0, 0, '0);
            for (int i = 0; i < 12; i++) begin
                op(0, 0, 0, 1, p > 0, 0, 16'h5000 + 16'(p * 16 + i));
                chk_flags("wrap");
            end
            op(0, 1, 0, 0, 0, 0, '0);
            chk_flags("wrap_commit");
        end
        drain();
        chk_flags("wrap_drain");

        // pkt_start while open restarts packet
        op(1, 0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) wr(16'h6000 + 16'(i));
        op(1, 0, 0, 1, 0, 0, 16'h6100);
        chk_flags("restart");
        wr(16'h6101);
        op(0, 1, 0, 0, 0, 0, '0);
        chk_flags("restart_commit");
        drain();

        // Commit/rollback in IDLE ignored; commit+rollback in OPEN means rollback
        wr(16'h7001);
        op(0, 1, 0, 0, 0, 0, '0);
        op(0, 0, 1, 0, 0, 0, '0);
        chk_flags("idle_ignore");
        op(1, 0, 0, 1, 0, 0, 16'h7002);
        op(0, 1, 1, 1, 0, 0, 16'h7003);
        chk_flags("commit_rollback");
        drain();

        // Reset mid-packet
        wr(16'h8001);
        wr(16'h8002);
        op(1, 0, 0, 1, 0, 0, 16'h8003);
        wr(16'h8004);
        do_reset("rst_mid");
        rd();
        chk_flags("rst_mid_rd");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
